rx_nco_bank: RTL and testbench

Parametrised phase and gain source for the RX core. It generates, for NUM_CH channels (DDC, demix, DUC1..DUC3 by default), SPC parallel NCO phase words per clock, matching the samples-per-clock of the ADC/DAC buses. It also ramps each channel's gain toward a programmed target. Configuration is double-buffered: host writes land in shadow registers, and all channels switch atomically on `commit`. The block sits between the control register interface and the mixer/DUC datapath.

---
 rtl/rx_core_pkg.sv | 28 ++
 rtl/rx_nco_lane_gen.sv | 57 +++++
 rtl/rx_nco_bank.sv | 129 ++++++++++++
 tb/tb_rx_nco_bank.sv | 312 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rx_core_pkg.sv
`default_nettype none
// ============================================================================
// Module      : rx_core_pkg
// Description : Shared defaults and channel indices for the RX core, plus a
//               width helper used by the NCO bank.
// Revision    : 1.0 - initial release
// ============================================================================
package rx_core_pkg;

  localparam int DEF_NUM_CH   = 5;
  localparam int DEF_SPC      = 8;
  localparam int DEF_PHASE_W  = 16;
  localparam int DEF_GAIN_W   = 8;
  localparam int DEF_RAMP_DIV = 16;

  localparam int CH_DDC   = 0;
  localparam int CH_DEMIX = 1;
  localparam int CH_DUC1  = 2;
  localparam int CH_DUC2  = 3;
  localparam int CH_DUC3  = 4;

  // Index width that never collapses to zero bits for a count of 1.
  function automatic int clog2_min1(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rx_nco_lane_gen.sv
`default_nettype none
// ============================================================================
// Module      : rx_nco_lane_gen
// Description : One channel's phase accumulator and its SPC lane adders.
//               The accumulator advances by SPC increments per clock; lane k
//               is registered as acc + k*inc.
// Ports       : i_clock, i_reset (async, active-high)
//               i_sync   - zero the accumulator (overrides the advance)
//               i_inc    - active phase increment
//               o_phase  - lane k at bits [k*PHASE_W +: PHASE_W]
// Revision    : 1.0 - initial release
// ============================================================================
module rx_nco_lane_gen #(
  parameter int SPC     = 8,
  parameter int PHASE_W = 16
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_sync,
  input  logic [PHASE_W-1:0]     i_inc,
  output logic [SPC*PHASE_W-1:0] o_phase
);
  import rx_core_pkg::*;

  logic [PHASE_W-1:0] r_acc;
  logic [PHASE_W-1:0] r_lane [SPC];
  logic [PHASE_W-1:0] w_step;

  // Constant multiplier: reduces to shifts/adds at synthesis.
  assign w_step = i_inc * PHASE_W'(SPC);

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_acc <= '0;
    end else if (i_sync) begin
      r_acc <= '0;
    end else begin
      r_acc <= r_acc + w_step;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int k = 0; k < SPC; k++) r_lane[k] <= '0;
    end else begin
      for (int k = 0; k < SPC; k++) r_lane[k] <= r_acc + i_inc * PHASE_W'(k);
    end
  end

  generate
    for (genvar k = 0; k < SPC; k++) begin : g_flat
      assign o_phase[k*PHASE_W +: PHASE_W] = r_lane[k];
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/rx_nco_bank.sv
`default_nettype none
// ============================================================================
// Module      : rx_nco_bank
// Description : Multi-channel NCO phase source with ramped per-channel gain.
//               Host writes fill shadow registers; a commit pulse copies all
//               shadows to the active increments and gain targets at once.
// Ports       : i_clock, i_reset (async, active-high)
//               i_cfg_valid/o_cfg_ready, i_cfg_ch, i_cfg_phase_inc,
//               i_cfg_gain                    - shadow write port
//               i_commit                      - shadow -> active, all channels
//               i_sync                        - zero all accumulators
//               o_phase_out  - ch c lane k at [(c*SPC+k)*PHASE_W +: PHASE_W]
//               o_gain_out   - ramped gain per channel
//               o_ramp_busy  - gain not yet at target, per channel
//               o_out_valid  - phase_out valid
//               o_cfg_err    - sticky, write to a non-existent channel
// Revision    : 1.0 - initial release
// ============================================================================
module rx_nco_bank #(
  parameter int NUM_CH   = rx_core_pkg::DEF_NUM_CH,
  parameter int SPC      = rx_core_pkg::DEF_SPC,
  parameter int PHASE_W  = rx_core_pkg::DEF_PHASE_W,
  parameter int GAIN_W   = rx_core_pkg::DEF_GAIN_W,
  parameter int RAMP_DIV = rx_core_pkg::DEF_RAMP_DIV
) (
  input  logic                                       i_clock,
  input  logic                                       i_reset,
  input  logic                                       i_cfg_valid,
  output logic                                       o_cfg_ready,
  input  logic [rx_core_pkg::clog2_min1(NUM_CH)-1:0] i_cfg_ch,
  input  logic [PHASE_W-1:0]                         i_cfg_phase_inc,
  input  logic [GAIN_W-1:0]                          i_cfg_gain,
  input  logic                                       i_commit,
  input  logic                                       i_sync,
  output logic [NUM_CH*SPC*PHASE_W-1:0]              o_phase_out,
  output logic [NUM_CH*GAIN_W-1:0]                   o_gain_out,
  output logic [NUM_CH-1:0]                          o_ramp_busy,
  output logic                                       o_out_valid,
  output logic                                       o_cfg_err
);
  import rx_core_pkg::*;

  localparam int                 c_ch_w     = clog2_min1(NUM_CH);
  localparam int                 c_div_w    = clog2_min1(RAMP_DIV);
  localparam logic [c_ch_w:0]    c_num_ch   = (c_ch_w+1)'(NUM_CH);
  localparam logic [c_div_w-1:0] c_div_last = c_div_w'(RAMP_DIV-1);

  logic                r_ready;
  logic                r_valid;
  logic                r_err;
  logic [c_div_w-1:0]  r_div;
  logic [PHASE_W-1:0]  r_shadow_inc  [NUM_CH];
  logic [GAIN_W-1:0]   r_shadow_gain [NUM_CH];
  logic [PHASE_W-1:0]  r_active_inc  [NUM_CH];
  logic [GAIN_W-1:0]   r_target      [NUM_CH];
  logic [GAIN_W-1:0]   r_gain        [NUM_CH];

  logic w_wr;
  logic w_ch_bad;
  logic w_tick;

  // Writes are refused during a commit cycle so a commit never sees a
  // half-updated shadow set; the host simply holds the write one more cycle.
  assign o_cfg_ready = r_ready & ~i_commit;
  assign w_wr        = i_cfg_valid & o_cfg_ready;
  assign w_ch_bad    = ({1'b0, i_cfg_ch} >= c_num_ch);
  assign w_tick      = (r_div == c_div_last);
  assign o_out_valid = r_valid;
  assign o_cfg_err   = r_err;

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_ready <= 1'b0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
      r_div   <= '0;
      for (int c = 0; c < NUM_CH; c++) begin
        r_shadow_inc[c]  <= '0;
        r_shadow_gain[c] <= '0;
        r_active_inc[c]  <= '0;
        r_target[c]      <= '0;
        r_gain[c]        <= '0;
      end
    end else begin
      r_ready <= 1'b1;
      r_valid <= r_ready;
      r_div   <= w_tick ? '0 : r_div + c_div_w'(1);
      if (w_wr && w_ch_bad) r_err <= 1'b1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (w_wr && !w_ch_bad && (i_cfg_ch == c_ch_w'(c))) begin
          r_shadow_inc[c]  <= i_cfg_phase_inc;
          r_shadow_gain[c] <= i_cfg_gain;
        end
        if (i_commit) begin
          r_active_inc[c] <= r_shadow_inc[c];
          r_target[c]     <= r_shadow_gain[c];
        end
        // Unit step toward the current target; a retarget just changes
        // direction from wherever the gain is now.
        if (w_tick) begin
          if (r_gain[c] < r_target[c]) begin
            r_gain[c] <= r_gain[c] + GAIN_W'(1);
          end else if (r_gain[c] > r_target[c]) begin
            r_gain[c] <= r_gain[c] - GAIN_W'(1);
          end
        end
      end
    end
  end

  generate
    for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
      rx_nco_lane_gen #(
        .SPC     (SPC),
        .PHASE_W (PHASE_W)
      ) u_lane_gen (
        .i_clock (i_clock),
        .i_reset (i_reset),
        .i_sync  (i_sync),
        .i_inc   (r_active_inc[c]),
        .o_phase (o_phase_out[c*SPC*PHASE_W +: SPC*PHASE_W])
      );
      assign o_gain_out[c*GAIN_W +: GAIN_W] = r_gain[c];
      assign o_ramp_busy[c]                 = (r_gain[c] != r_target[c]);
    end
  endgenerate

endmodule
`default_nettype wire

// File: tb/tb_rx_nco_bank.sv
`default_nettype none
// ============================================================================
// Module      : tb_rx_nco_bank
// Description : Self-checking bench for rx_nco_bank: reference model of the
//               bank's arithmetic rules, per-cycle compare, and directed
//               scenarios with literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_rx_nco_bank;

  localparam int NUM_CH   = 5;
  localparam int SPC      = 8;
  localparam int PHASE_W  = 16;
  localparam int GAIN_W   = 8;
  localparam int RAMP_DIV = 16;
  localparam int PW       = NUM_CH*SPC*PHASE_W;

  logic                      clk = 1'b0;
  logic                      rst = 1'b0;
  logic                      cfg_valid = 1'b0;
  logic                      cfg_ready;
  logic [2:0]                cfg_ch = '0;
  logic [PHASE_W-1:0]        cfg_inc = '0;
  logic [GAIN_W-1:0]         cfg_gain = '0;
  logic                      commit = 1'b0;
  logic                      sync = 1'b0;
  logic [PW-1:0]             phase_out;
  logic [NUM_CH*GAIN_W-1:0]  gain_out;
  logic [NUM_CH-1:0]         ramp_busy;
  logic                      out_valid;
  logic                      cfg_err;

  int n_tests = 0;
  int n_fail  = 0;
  bit chk_on  = 1'b0;

  always #5 clk = ~clk;

  rx_nco_bank #(
    .NUM_CH(NUM_CH), .SPC(SPC), .PHASE_W(PHASE_W), .GAIN_W(GAIN_W), .RAMP_DIV(RAMP_DIV)
  ) dut (
    .i_clock(clk), .i_reset(rst), .i_cfg_valid(cfg_valid), .o_cfg_ready(cfg_ready),
    .i_cfg_ch(cfg_ch), .i_cfg_phase_inc(cfg_inc), .i_cfg_gain(cfg_gain),
    .i_commit(commit), .i_sync(sync), .o_phase_out(phase_out), .o_gain_out(gain_out),
    .o_ramp_busy(ramp_busy), .o_out_valid(out_valid), .o_cfg_err(cfg_err)
  );

  // ---------------- reference model ----------------
  logic [PHASE_W-1:0] m_sh_inc  [NUM_CH];
  logic [GAIN_W-1:0]  m_sh_gain [NUM_CH];
  logic [PHASE_W-1:0] m_inc     [NUM_CH];
  logic [GAIN_W-1:0]  m_tgt     [NUM_CH];
  logic [GAIN_W-1:0]  m_gain    [NUM_CH];
  logic [PHASE_W-1:0] m_acc     [NUM_CH];
  logic [PHASE_W-1:0] m_ph      [NUM_CH][SPC];
  int                 m_edges;
  bit                 m_err;

  always @(posedge clk or posedge rst) begin
    bit accept;
    bit tick;
    if (rst) begin
      for (int c = 0; c < NUM_CH; c++) begin
        m_sh_inc[c] = '0; m_sh_gain[c] = '0; m_inc[c] = '0;
        m_tgt[c] = '0; m_gain[c] = '0; m_acc[c] = '0;
        for (int k = 0; k < SPC; k++) m_ph[c][k] = '0;
      end
      m_edges = 0;
      m_err   = 1'b0;
    end else begin
      accept = (m_edges >= 1) && cfg_valid && !commit;
      tick   = ((m_edges + 1) % RAMP_DIV) == 0;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < SPC; k++) m_ph[c][k] = 16'(m_acc[c] + k*m_inc[c]);
        m_acc[c] = sync ? 16'h0 : 16'(m_acc[c] + SPC*m_inc[c]);
        if (tick && m_gain[c] < m_tgt[c]) m_gain[c] = m_gain[c] + 8'd1;
        else if (tick && m_gain[c] > m_tgt[c]) m_gain[c] = m_gain[c] - 8'd1;
        if (commit) begin
          m_inc[c] = m_sh_inc[c];
          m_tgt[c] = m_sh_gain[c];
        end
      end
      if (accept) begin
        if (cfg_ch < NUM_CH) begin
          m_sh_inc[cfg_ch]  = cfg_inc;
          m_sh_gain[cfg_ch] = cfg_gain;
        end else begin
          m_err = 1'b1;
        end
      end
      m_edges++;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    #1;
    if (chk_on) begin
      logic [PW-1:0]            ep;
      logic [NUM_CH*GAIN_W-1:0] eg;
      logic [NUM_CH-1:0]        eb;
      for (int c = 0; c < NUM_CH; c++) begin
        for (int k = 0; k < SPC; k++) ep[(c*SPC+k)*PHASE_W +: PHASE_W] = m_ph[c][k];
        eg[c*GAIN_W +: GAIN_W] = m_gain[c];
        eb[c] = (m_gain[c] != m_tgt[c]);
      end
      n_tests++;
      if (phase_out !== ep) begin
        n_fail++;
        $display("FAIL model_phase_out got %h exp %h", phase_out, ep);
      end
      n_tests++;
      if (gain_out !== eg) begin
        n_fail++;
        $display("FAIL model_gain_out got %h exp %h", gain_out, eg);
      end
      n_tests++;
      if (ramp_busy !== eb) begin
        n_fail++;
        $display("FAIL model_ramp_busy got %b exp %b", ramp_busy, eb);
      end
      n_tests++;
      if (cfg_ready !== ((m_edges >= 1) && !commit)) begin
        n_fail++;
        $display("FAIL model_cfg_ready got %b exp %b", cfg_ready, (m_edges >= 1) && !commit);
      end
      n_tests++;
      if (out_valid !== (m_edges >= 2)) begin
        n_fail++;
        $display("FAIL model_out_valid got %b exp %b", out_valid, m_edges >= 2);
      end
      n_tests++;
      if (cfg_err !== m_err) begin
        n_fail++;
        $display("FAIL model_cfg_err got %b exp %b", cfg_err, m_err);
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s got 0x%0h exp 0x%0h", nm, act, exp);
    end
  endtask

  function automatic logic [PHASE_W-1:0] lane(input int c, input int k);
    return phase_out[(c*SPC+k)*PHASE_W +: PHASE_W];
  endfunction

  function automatic logic [GAIN_W-1:0] gain(input int c);
    return gain_out[c*GAIN_W +: GAIN_W];
  endfunction

  task automatic step();
    @(negedge clk);
  endtask

  task automatic write(input int ch, input logic [PHASE_W-1:0] inc, input logic [GAIN_W-1:0] g);
    cfg_valid = 1'b1; cfg_ch = 3'(ch); cfg_inc = inc; cfg_gain = g;
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic commit_pulse();
    commit = 1'b1;
    @(negedge clk);
    commit = 1'b0;
  endtask

  task automatic sync_pulse();
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

  // ---------------- directed scenarios ----------------
  initial begin
    int n;
    logic [GAIN_W-1:0] prev;

    // Reset and release.
    @(negedge clk);
    rst = 1'b1;
    chk_on = 1'b1;
    repeat (3) step();
    chk("rst_ready", cfg_ready, 0);
    chk("rst_valid", out_valid, 0);
    chk("rst_err", cfg_err, 0);
    rst = 1'b0;
    #1 chk("rel_ready_e0", cfg_ready, 0);
    step();
    chk("rel_ready_e1", cfg_ready, 1);
    chk("rel_valid_e1", out_valid, 0);
    step();
    chk("rel_valid_e2", out_valid, 1);

    // Lanes: ch0 inc 0x0100, commit, then sync.
    write(0, 16'h0100, 8'd0);
    commit_pulse();
    sync_pulse();
    step();
    for (int k = 0; k < SPC; k++) chk($sformatf("lanes_c0_a_k%0d", k), lane(0, k), 16'(k*16'h0100));
    chk("lanes_c3_zero", lane(3, 5), 16'h0000);
    step();
    for (int k = 0; k < SPC; k++) chk($sformatf("lanes_c0_b_k%0d", k), lane(0, k), 16'(16'h0800 + k*16'h0100));

    // Wrap: ch1 inc 0x4000, commit together with sync.
    write(1, 16'h4000, 8'd0);
    commit = 1'b1; sync = 1'b1;
    step();
    commit = 1'b0; sync = 1'b0;
    step();
    for (int k = 0; k < SPC; k++) chk($sformatf("wrap_a_k%0d", k), lane(1, k), 16'((k % 4) * 16'h4000));
    step();
    for (int k = 0; k < SPC; k++) chk($sformatf("wrap_b_k%0d", k), lane(1, k), 16'((k % 4) * 16'h4000));

    // Ramp up: ch2 gain 4.
    write(2, 16'h0000, 8'd4);
    commit_pulse();
    chk("ramp_busy_start", ramp_busy[2], 1);
    n = 0;
    while (gain(2) != 8'd4 && n < 100) begin step(); n++; end
    chk("ramp_reach4", gain(2), 8'd4);
    chk("ramp_time_ok", (n >= 48 && n <= 80), 1);
    chk("ramp_busy_done", ramp_busy[2], 0);

    // Ramp down toward 0, retarget to 1 once gain is 3.
    write(2, 16'h0000, 8'd0);
    commit_pulse();
    write(2, 16'h0000, 8'd1);
    n = 0;
    while (gain(2) != 8'd3 && n < 40) begin step(); n++; end
    chk("retarget_at3", gain(2), 8'd3);
    commit_pulse();
    prev = gain(2);
    n = 0;
    while (gain(2) != 8'd1 && n < 60) begin
      step(); n++;
      if (gain(2) != prev) begin
        chk("retarget_step", gain(2), prev - 8'd1);
        prev = gain(2);
      end
    end
    repeat (20) step();
    chk("retarget_final", gain(2), 8'd1);
    chk("retarget_busy", ramp_busy[2], 0);

    // Error: channel 7 does not exist.
    write(7, 16'h1234, 8'h55);
    chk("err_set", cfg_err, 1);
    commit_pulse();
    repeat (5) step();
    chk("err_sticky", cfg_err, 1);
    chk("err_no_shadow_c2", ramp_busy[2], 0);

    // Reset in the middle of a ramp.
    write(3, 16'h0000, 8'd200);
    commit_pulse();
    repeat (40) step();
    chk("midramp_nonzero", (gain(3) != 8'd0), 1);
    rst = 1'b1;
    #1;
    chk("mr_phase_zero", (phase_out == '0), 1);
    chk("mr_gain_zero", (gain_out == '0), 1);
    chk("mr_busy_zero", ramp_busy, 0);
    chk("mr_ready", cfg_ready, 0);
    chk("mr_valid", out_valid, 0);
    chk("mr_err", cfg_err, 0);
    repeat (3) step();
    rst = 1'b0;
    step();
    chk("mr_ready_e1", cfg_ready, 1);
    chk("mr_valid_e1", out_valid, 0);
    step();
    chk("mr_valid_e2", out_valid, 1);
    chk("mr_err_after", cfg_err, 0);

    // Handshake: write presented together with commit.
    cfg_valid = 1'b1; cfg_ch = 3'd4; cfg_inc = 16'h0010; cfg_gain = 8'd9; commit = 1'b1;
    #1 chk("hs_ready_commit", cfg_ready, 0);
    step();
    commit = 1'b0;
    #1 chk("hs_ready_next", cfg_ready, 1);
    step();
    cfg_valid = 1'b0;
    sync_pulse();
    step();
    chk("hs_not_active_l1", lane(4, 1), 16'h0000);
    chk("hs_not_active_busy", ramp_busy[4], 0);
    commit_pulse();
    sync_pulse();
    step();
    chk("hs_active_l1", lane(4, 1), 16'h0010);
    chk("hs_active_l7", lane(4, 7), 16'h0070);
    chk("hs_active_busy", ramp_busy[4], 1);

    repeat (3) step();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
